// File: rtl/multdiv_issue_unit.sv
`timescale 1ns/1ps
// multdiv_issue_unit
// Front-end and writeback stage for the iterative mult/div unit. Accepts one
// tagged MUL/DIV op, holds its operands on the unit's inputs, fires a single
// start pulse, captures the result and offers it to the CDB arbiter.
//
// Optional build feature (define MULTDIV_TIMEOUT_EN): an 8-bit WAIT-state
// counter forces a DONE with wb_result = 0 and wb_exception = 1 once it
// reaches TIMEOUT cycles without an accepted result-ready.
module multdiv_issue_unit #(
  parameter int TAG_W   = 6,
  parameter int TIMEOUT = 64
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_is_div,
  input  logic [31:0]      in_opA,
  input  logic [31:0]      in_opB,
  input  logic [TAG_W-1:0] in_tag,
  output logic [31:0]      md_operandA,
  output logic [31:0]      md_operandB,
  output logic             md_ctrl_MULT,
  output logic             md_ctrl_DIV,
  input  logic [31:0]      md_result,
  input  logic             md_exception,
  input  logic             md_resultRDY,
  output logic             wb_valid,
  input  logic             wb_ready,
  output logic [31:0]      wb_result,
  output logic             wb_exception,
  output logic [TAG_W-1:0] wb_tag,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [TAG_W-1:0] tag_q;
  logic             wait_armed;   // set after the first WAIT cycle
  logic             accept;
  logic             capture;
  logic             timeout_hit;

  // The timeout counter is 8 bits wide, so the limit must fit in it.
  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
    $error("multdiv_issue_unit: TIMEOUT must be in 1..255");
  end

  assign in_ready = (state == S_IDLE) && !flush;
  assign busy     = (state != S_IDLE);
  assign accept   = in_valid && in_ready;
  // A ready seen in START or the first WAIT cycle may be left over from the
  // previous op, so only a ready after that point is taken as a result.
  assign capture  = (state == S_WAIT) && wait_armed && md_resultRDY;

`ifdef MULTDIV_TIMEOUT_EN
  logic [7:0] wait_cnt;

  // A ready arriving in the timeout cycle wins over the timeout.
  assign timeout_hit = (state == S_WAIT) && !capture
                       && (wait_cnt == 8'(TIMEOUT - 1));

  // WAIT cycle counter: cleared on the way into WAIT, counts each WAIT cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if (state == S_START) begin
      wait_cnt <= '0;
    end else if (state == S_WAIT) begin
      wait_cnt <= wait_cnt + 8'd1;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      // NOTE: non-blocking assignments in clocked blocks so every register
      // samples pre-edge values regardless of block or statement order.
      state <= state_nxt;
    end
  end

  // Next-state logic; flush overrides every other transition.
  always_comb begin
    // NOTE: default assigned first so no path leaves state_nxt unassigned,
    // which would otherwise infer a latch.
    state_nxt = state;
    if (flush) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (accept) state_nxt = S_START;
        S_START: state_nxt = S_WAIT;
        S_WAIT:  if (capture || timeout_hit) state_nxt = S_DONE;
        S_DONE:  if (wb_ready) state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // Operand/tag holding registers, start pulse and stale-ready mask.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      md_operandA  <= '0;
      md_operandB  <= '0;
      md_ctrl_MULT <= 1'b0;
      md_ctrl_DIV  <= 1'b0;
      tag_q        <= '0;
      wait_armed   <= 1'b0;
    end else begin
      // The pulse is raised only on the accept edge, so it lasts exactly the
      // START cycle; operands stay put until the next accepted op.
      md_ctrl_MULT <= 1'b0;
      md_ctrl_DIV  <= 1'b0;
      if (accept) begin
        md_operandA  <= in_opA;
        md_operandB  <= in_opB;
        tag_q        <= in_tag;
        md_ctrl_MULT <= !in_is_div;
        md_ctrl_DIV  <= in_is_div;
      end
      if (state == S_START) begin
        wait_armed <= 1'b0;
      end else if (state == S_WAIT) begin
        wait_armed <= 1'b1;
      end
    end
  end

  // Writeback register: capture on result or timeout, release on grant.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wb_valid     <= 1'b0;
      wb_result    <= '0;
      wb_exception <= 1'b0;
      wb_tag       <= '0;
    end else if (flush) begin
      wb_valid <= 1'b0;
    end else if (capture) begin
      wb_valid     <= 1'b1;
      wb_result    <= md_result;
      wb_exception <= md_exception;
      wb_tag       <= tag_q;
    end else if (timeout_hit) begin
      wb_valid     <= 1'b1;
      wb_result    <= '0;
      wb_exception <= 1'b1;
      wb_tag       <= tag_q;
    end else if (state == S_DONE && wb_ready) begin
      wb_valid <= 1'b0;
    end
  end

endmodule
